demux_1v4: RTL and testbench
============================

// Module: demux_1v4
// PURPOSE
//   1-to-4 demultiplexer with registered outputs. Routes a DATA_W-bit input E to
//   the output lane selected by sel; all unselected lanes are driven to zero.
//   Used as a generic steering element (enable fan-out, one-hot decode of a
//   strobe) inside synchronous datapaths of the FPGA utility library.
// PARAMETERS
//   DATA_W  1  width of input E and of each of the 4 output lanes
//   REG_OUT 1  1: outputs registered (1-cycle latency); 0: purely combinational path
// PORTS
//   clk  input  1         system clock, all state updates on rising edge
//   rst  input  1         synchronous reset, active-high
//   E    input  DATA_W    data/enable to be routed
//   sel  input  2         lane select, 0..3
//   S    output 4*DATA_W  lanes; lane k = S[k*DATA_W +: DATA_W]
// BEHAVIOUR
//   - Interface: one clock (clk); reset is synchronous and active-high (rst).
//   - Function: lane[sel] = E; every lane k != sel = 0. For DATA_W=1 this is
//     S = E ? (4'b0001 << sel) : 4'b0000.
//   - REG_OUT=1: S updates on the rising clk edge following the input change;
//     latency exactly 1 cycle, no bubbles, new sel/E accepted every cycle.
//   - REG_OUT=0: S is a combinational function of E and sel; rst has no effect.
//   - Reset (REG_OUT=1): rst sampled high at a clk edge -> S = 0 at that edge;
//     rst has priority over E/sel. Output resumes tracking inputs on the first
//     edge with rst low (value shown is the inputs sampled at that edge).
//   - Reset mid-operation: any in-flight registered value is discarded; S = 0.
//   - At most one lane is ever non-zero (one-hot-or-zero per lane for DATA_W=1).
//   - sel change with E held: old lane returns to 0 and new lane takes E in
//     the same update (no cycle where two lanes are non-zero).
//   - E = 0 -> all lanes 0 regardless of sel.
//   - sel is full-range 2-bit; no illegal values. X on sel is not propagated
//     intentionally; verification treats it as out of scope.
//   - No internal state beyond the output register; no counters, no FSM.
// TESTING
//   - Sweep: for sel=0..3, apply E=0 then E=1 (DATA_W=1) -> S=0x0 then
//     S=0x1,0x2,0x4,0x8 respectively, one cycle after each apply.
//   - Reset: drive E=1, sel=2 (S=0x4), assert rst 1 cycle -> S=0x0 at that
//     edge; deassert -> S=0x4 on next edge.
//   - Back-to-back: sel 0,1,2,3 on consecutive cycles with E=1 -> S shows
//     0x1,0x2,0x4,0x8 on consecutive cycles, never two bits set.
//   - Wide data (DATA_W=8): E=0xA5, sel=3 -> S=0xA5000000; sel=0 -> 0x000000A5.
//   - REG_OUT=0: E=1, sel=1 -> S=0x2 in the same delta, no clk needed.
//   - Self-check every cycle against reference model S == E << (sel*DATA_W).

Source files
------------

// File: rtl/demux_1v4.sv
// demux_1v4 : 1-to-4 demultiplexer.
// The DATA_W-bit input E is steered onto the lane picked by sel and every
// other lane is held at zero. With REG_OUT=1 the lanes come from an output
// register (one cycle of latency, synchronous active-high reset). With
// REG_OUT=0 the lanes are a purely combinational function of E and sel.
// Lane k occupies S[k*DATA_W +: DATA_W].
module demux_1v4 #(
  parameter int DATA_W  = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     E,
  input  logic [1:0]            sel,
  output logic [4*DATA_W-1:0]   S
);

  // Decoded lane pattern for the current inputs. At most one lane can
  // carry E, so the one-hot-or-zero property holds on this net and on
  // anything registered from it.
  logic [4*DATA_W-1:0] lanes_s;

  // Steer E onto the selected lane; all other lanes stay zero.
  always_comb begin
    lanes_s = {(4*DATA_W){1'b0}};
    case (sel)
      2'd0:    lanes_s[0*DATA_W +: DATA_W] = E;
      2'd1:    lanes_s[1*DATA_W +: DATA_W] = E;
      2'd2:    lanes_s[2*DATA_W +: DATA_W] = E;
      2'd3:    lanes_s[3*DATA_W +: DATA_W] = E;
      default: lanes_s = {(4*DATA_W){1'b0}};
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [4*DATA_W-1:0] s_r;

      // Output register; reset wins over the decoded value so an in-flight
      // lane pattern is discarded when rst is sampled high.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_r <= {(4*DATA_W){1'b0}};
        end else begin
          s_r <= lanes_s;
        end
      end

      assign S = s_r;
    end else begin : g_comb
      // Clock and reset have no function on the combinational path; they
      // are kept as ports so both variants share one interface.
      logic unused_s;
      assign unused_s = clk ^ rst;
      assign S = lanes_s;
    end
  endgenerate

endmodule

// File: tb/tb_demux_1v4.sv
// tb_demux_1v4 : self-checking bench for demux_1v4.
// Three instances: DATA_W=1 registered, DATA_W=8 registered and DATA_W=1
// combinational. Expected lanes come from E << (sel*DATA_W), with the
// registered instances taking one clock and forcing zero under rst.
module tb_demux_1v4;

  logic        clk;
  logic        rst;
  logic [0:0]  e1;
  logic [7:0]  e8;
  logic [1:0]  sel;
  logic [3:0]  s_r1;
  logic [31:0] s_r8;
  logic [3:0]  s_c1;

  int checks;
  int passes;

  logic [31:0] exp1;
  logic [31:0] exp8;

  demux_1v4 #(.DATA_W(1), .REG_OUT(1'b1)) dut_r1 (
    .clk (clk), .rst (rst), .E (e1), .sel (sel), .S (s_r1)
  );

  demux_1v4 #(.DATA_W(8), .REG_OUT(1'b1)) dut_r8 (
    .clk (clk), .rst (rst), .E (e8), .sel (sel), .S (s_r8)
  );

  demux_1v4 #(.DATA_W(1), .REG_OUT(1'b0)) dut_c1 (
    .clk (clk), .rst (rst), .E (e1), .sel (sel), .S (s_c1)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected lane carries e, shifted up by whole lanes.
  function automatic logic [31:0] model(input logic [31:0] e, input int s, input int w);
    return e << (s * w);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
  endtask

  // One cycle: drive inputs on the falling edge, check the combinational
  // instance and that registered outputs have not moved yet, then check the
  // registered outputs just after the rising edge.
  task automatic step(input logic r, input logic [0:0] e, input logic [7:0] w, input logic [1:0] s);
    @(negedge clk);
    rst = r; e1 = e; e8 = w; sel = s;
    #1;
    chk("comb_w1", {28'd0, s_c1}, model({31'd0, e}, int'(s), 1));
    chk("hold_w1", {28'd0, s_r1}, exp1);
    chk("hold_w8", s_r8, exp8);
    exp1 = r ? 32'd0 : model({31'd0, e}, int'(s), 1);
    exp8 = r ? 32'd0 : model({24'd0, w}, int'(s), 8);
    @(posedge clk);
    #1;
    chk("reg_w1", {28'd0, s_r1}, exp1);
    chk("reg_w8", s_r8, exp8);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1; e1 = 1'b1; e8 = 8'hFF; sel = 2'd3;
    exp1 = 32'd0;
    exp8 = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset state
    chk("rst_w1", {28'd0, s_r1}, 32'd0);
    chk("rst_w8", s_r8, 32'd0);

    // Sweep: E=0 then E=1 on each lane
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 8'h00, k[1:0]);
      step(1'b0, 1'b1, 8'h5A, k[1:0]);
    end

    // Reset mid-operation: S=0x4, rst one cycle, then 0x4 again
    step(1'b0, 1'b1, 8'h3C, 2'd2);
    step(1'b1, 1'b1, 8'h3C, 2'd2);
    step(1'b0, 1'b1, 8'h3C, 2'd2);

    // Back-to-back lane changes with E held
    step(1'b0, 1'b1, 8'hA5, 2'd0);
    step(1'b0, 1'b1, 8'hA5, 2'd1);
    step(1'b0, 1'b1, 8'hA5, 2'd2);
    step(1'b0, 1'b1, 8'hA5, 2'd3);

    // Wide data: 0xA5 on lane 3 then lane 0
    step(1'b0, 1'b1, 8'hA5, 2'd3);
    chk("wide_lane3", s_r8, 32'hA500_0000);
    step(1'b0, 1'b1, 8'hA5, 2'd0);
    chk("wide_lane0", s_r8, 32'h0000_00A5);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
